// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Round-robin write-back arbiter for a register file, combined with a
//   per-register pending scoreboard. Up to NUM_REQ producers compete for
//   the single register-file write port. One winner is granted per cycle,
//   and its write is registered one cycle later. The scoreboard marks a
//   register as pending when it is reserved at issue time. A write to that
//   register clears the mark.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester write request
//   req_addr   packed destination addresses, requester i at [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
//   req_data   packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  one-hot-or-zero grant (combinational)
//   rsv_valid  reserve a destination register this cycle
//   rsv_addr   register to reserve
//   write_en   register-file write enable (one cycle after the grant)
//   regw       register-file write address
//   dataw      register-file write data
//   pending    scoreboard; bit r set while a write to register r is outstanding
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             rsv_valid,
  input  logic [REG_ADDR_WIDTH-1:0]        rsv_addr,
  output logic                             write_en,
  output logic [REG_ADDR_WIDTH-1:0]        regw,
  output logic [DATA_WIDTH-1:0]            dataw,
  output logic [(2**REG_ADDR_WIDTH)-1:0]   pending
);

  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

  // Unpacked views of the packed request buses, indexed by requester.
  logic [REG_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]     data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [IDX_W-1:0]          last_grant_q, last_grant_d;
  logic                      write_en_q,   write_en_d;
  logic [REG_ADDR_WIDTH-1:0] regw_q,       regw_d;
  logic [DATA_WIDTH-1:0]     dataw_q,      dataw_d;
  logic [NUM_REGS-1:0]       pending_q,    pending_d;

  logic                      gnt_found;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      xfer;

  // Round-robin search. Candidates are visited starting one past the last
  // winner and wrapping around. The first valid candidate wins. With
  // k = NUM_REQ, the last winner itself is visited last, so a lone
  // requester is still granted every cycle.
  always_comb begin : grant_search
    logic [IDX_W-1:0] cand;
    // NOTE: every combinational output gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Reset masks the grant, so nothing transfers while rst is high.
  always_comb begin
    req_ready = '0;
    if (!rst && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign xfer = |req_ready;

  always_comb begin
    write_en_d   = xfer;
    regw_d       = regw_q;
    dataw_d      = dataw_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      regw_d       = addr_arr[gnt_idx];
      dataw_d      = data_arr[gnt_idx];
      last_grant_d = gnt_idx;
    end

    // The clear is applied first and the set second. When both hit the same
    // register in one cycle, the new reservation survives.
    pending_d = pending_q;
    if (write_en_q) begin
      pending_d[regw_q] = 1'b0;
    end
    if (rsv_valid) begin
      pending_d[rsv_addr] = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard is a flop vector, not a RAM, so it can be cleared
      // in a single reset cycle. This also drops a write granted just before reset.
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      write_en_q   <= 1'b0;
      regw_q       <= '0;
      dataw_q      <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      write_en_q   <= write_en_d;
      regw_q       <= regw_d;
      dataw_q      <= dataw_d;
      pending_q    <= pending_d;
    end
  end

  assign write_en = write_en_q;
  assign regw     = regw_q;
  assign dataw    = dataw_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed scenarios plus a randomized run of regfile_wb_arbiter. The
// reference model keeps the scoreboard as a plain bit array and the
// arbitration as a "next valid index after the last winner" search.
// Inputs change 1 ns after a rising edge. req_ready is sampled 2 ns later,
// and the registered outputs are sampled 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 3;
  localparam int NR = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [AW-1:0]     r_addr [N];
  logic [DW-1:0]     r_data [N];
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic              write_en;
  logic [AW-1:0]     regw;
  logic [DW-1:0]     dataw;
  logic [NR-1:0]     pending;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_lg;
  logic          m_we;
  logic [AW-1:0] m_regw;
  logic [DW-1:0] m_dataw;
  logic [NR-1:0] m_pend;
  int            m_last_acc;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = r_addr[i];
      req_data[i*DW +: DW] = r_data[i];
    end
  end

  regfile_wb_arbiter #(
    .REG_ADDR_WIDTH(AW),
    .DATA_WIDTH    (DW),
    .NUM_REQ       (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsv_valid(rsv_valid),
    .rsv_addr (rsv_addr),
    .write_en (write_en),
    .regw     (regw),
    .dataw    (dataw),
    .pending  (pending)
  );

  // First valid requester after the last winner, wrapping around; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int lg);
    for (int k = 1; k <= N; k++) begin
      if (v[(lg + k) % N]) return (lg + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    if (!rst) begin
      g = pick(req_valid, m_lg);
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  // Advance one clock and move the model across the same edge.
  task automatic tick();
    int g;
    g = rst ? -1 : pick(req_valid, m_lg);
    @(posedge clk);
    if (rst) begin
      m_lg       = N - 1;
      m_we       = 1'b0;
      m_regw     = '0;
      m_dataw    = '0;
      m_pend     = '0;
      m_last_acc = -1;
    end else begin
      if (m_we) m_pend[m_regw] = 1'b0;
      if (rsv_valid) m_pend[rsv_addr] = 1'b1;
      m_we = (g >= 0);
      if (g >= 0) begin
        m_regw  = r_addr[g];
        m_dataw = r_data[g];
        m_lg    = g;
      end
      m_last_acc = g;
    end
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = AW'(i + 4);
      r_data[i] = DW'(8'hC0 + i);
    end
    rsv_valid = 1'b1;
    rsv_addr  = AW'(5);
    #2;
    total++;
    if (req_ready !== '0) begin
      bad++; $display("FAIL reset_ready got=%b want=000", req_ready);
    end
    tick();
    tick();
    total++;
    if (write_en !== 1'b0) begin
      bad++; $display("FAIL reset_we got=%b want=0", write_en);
    end
    total++;
    if (regw !== '0 || dataw !== '0) begin
      bad++; $display("FAIL reset_wdata got regw=%h dataw=%h want 0/00", regw, dataw);
    end
    total++;
    if (pending !== '0) begin
      bad++; $display("FAIL reset_pending got=%h want=0000", pending);
    end
    rst       = 1'b0;
    req_valid = '0;
    rsv_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [4];
    int           idx [4];
    seq[0] = 3'b001; idx[0] = 0;
    seq[1] = 3'b010; idx[1] = 1;
    seq[2] = 3'b100; idx[2] = 2;
    seq[3] = 3'b001; idx[3] = 0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = AW'(i + 1);
      r_data[i] = DW'(8'h10 + i);
    end
    req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #2;
      total++;
      if (req_ready !== seq[c]) begin
        bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", c, req_ready, seq[c]);
      end
      tick();
      total++;
      if (write_en !== 1'b1 || regw !== AW'(idx[c] + 1) || dataw !== DW'(8'h10 + idx[c])) begin
        bad++;
        $display("FAIL rr_write[%0d] got we=%b regw=%h dataw=%h want we=1 regw=%h dataw=%h",
                 c, write_en, regw, dataw, AW'(idx[c] + 1), DW'(8'h10 + idx[c]));
      end
    end
    req_valid = '0;
    tick();
    total++;
    if (write_en !== 1'b0 || regw !== AW'(1) || dataw !== 8'h10) begin
      bad++; $display("FAIL rr_idle got we=%b regw=%h dataw=%h want we=0 regw=1 dataw=10",
                      write_en, regw, dataw);
    end
  endtask

  task automatic test_single();
    req_valid = 3'b100;
    r_addr[2] = AW'(5);
    r_data[2] = 8'hA5;
    #2;
    total++;
    if (req_ready !== 3'b100) begin
      bad++; $display("FAIL single_grant got=%b want=100", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (write_en !== 1'b1 || regw !== AW'(5) || dataw !== 8'hA5) begin
      bad++; $display("FAIL single_write got we=%b regw=%h dataw=%h want we=1 regw=5 dataw=a5",
                      write_en, regw, dataw);
    end
    tick();
    total++;
    if (write_en !== 1'b0 || regw !== AW'(5) || dataw !== 8'hA5) begin
      bad++; $display("FAIL single_after got we=%b regw=%h dataw=%h want we=0 regw=5 dataw=a5",
                      write_en, regw, dataw);
    end
  endtask

  task automatic test_reserve();
    rsv_valid = 1'b1;
    rsv_addr  = AW'(3);
    tick();
    rsv_valid = 1'b0;
    total++;
    if (pending !== 16'h0008) begin
      bad++; $display("FAIL rsv_set got=%h want=0008", pending);
    end
    req_valid = 3'b001;
    r_addr[0] = AW'(3);
    r_data[0] = 8'h33;
    tick();
    req_valid = '0;
    total++;
    if (pending !== 16'h0008 || write_en !== 1'b1 || regw !== AW'(3)) begin
      bad++; $display("FAIL rsv_inflight got pend=%h we=%b regw=%h want pend=0008 we=1 regw=3",
                      pending, write_en, regw);
    end
    tick();
    total++;
    if (pending !== 16'h0000) begin
      bad++; $display("FAIL rsv_clear got=%h want=0000", pending);
    end
  endtask

  task automatic test_set_wins();
    req_valid = 3'b010;
    r_addr[1] = AW'(7);
    r_data[1] = 8'h77;
    tick();
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_addr  = AW'(7);
    tick();
    total++;
    if (pending !== 16'h0080) begin
      bad++; $display("FAIL set_wins got=%h want=0080", pending);
    end
    // A second reservation of an already-pending register stays a single bit.
    tick();
    rsv_valid = 1'b0;
    total++;
    if (pending !== 16'h0080) begin
      bad++; $display("FAIL rsv_twice got=%h want=0080", pending);
    end
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    tick();
    total++;
    if (pending !== 16'h0000) begin
      bad++; $display("FAIL one_write_clears got=%h want=0000", pending);
    end
    // A write to an unreserved register leaves its bit at 0.
    req_valid = 3'b001;
    r_addr[0] = AW'(12);
    tick();
    req_valid = '0;
    tick();
    total++;
    if (pending !== 16'h0000 || regw !== AW'(12)) begin
      bad++; $display("FAIL unreserved_write got pend=%h regw=%h want pend=0000 regw=c",
                      pending, regw);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 3'b010;
    #2;
    total++;
    if (req_ready !== 3'b010) begin
      bad++; $display("FAIL wrap_first got=%b want=010", req_ready);
    end
    tick();
    req_valid = 3'b011;
    #2;
    total++;
    if (req_ready !== 3'b001) begin
      bad++; $display("FAIL wrap_to0 got=%b want=001", req_ready);
    end
    tick();
    #2;
    total++;
    if (req_ready !== 3'b010) begin
      bad++; $display("FAIL wrap_then1 got=%b want=010", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    rsv_valid = 1'b1;
    rsv_addr  = AW'(9);
    for (int i = 0; i < N; i++) begin
      r_addr[i] = AW'(i + 10);
      r_data[i] = DW'(8'h50 + i);
    end
    req_valid = 3'b111;
    tick();
    rsv_valid = 1'b0;
    rst       = 1'b1;
    #2;
    total++;
    if (req_ready !== '0) begin
      bad++; $display("FAIL midrst_ready got=%b want=000", req_ready);
    end
    tick();
    total++;
    if (write_en !== 1'b0 || pending !== '0 || regw !== '0 || dataw !== '0) begin
      bad++; $display("FAIL midrst_state got we=%b pend=%h regw=%h dataw=%h want all 0",
                      write_en, pending, regw, dataw);
    end
    rst = 1'b0;
    #2;
    total++;
    if (req_ready !== 3'b001) begin
      bad++; $display("FAIL midrst_first got=%b want=001", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (write_en !== 1'b1 || regw !== AW'(10) || dataw !== 8'h50) begin
      bad++; $display("FAIL midrst_write got we=%b regw=%h dataw=%h want we=1 regw=a dataw=50",
                      write_en, regw, dataw);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int c = 0; c < 400; c++) begin
      // A requester keeps its request stable until it has been accepted.
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_last_acc == i) begin
          if ($urandom_range(0, 2) != 0) begin
            req_valid[i] = 1'b1;
            r_addr[i]    = AW'($urandom);
            r_data[i]    = DW'($urandom);
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_addr  = AW'($urandom);
      rst       = ($urandom_range(0, 49) == 0);
      #2;
      er = exp_ready();
      total++;
      if (req_ready !== er) begin
        bad++; $display("FAIL rand_grant[%0d] got=%b want=%b", c, req_ready, er);
      end
      tick();
      total++;
      if (write_en !== m_we || regw !== m_regw || dataw !== m_dataw || pending !== m_pend) begin
        bad++;
        $display("FAIL rand_out[%0d] got we=%b regw=%h dataw=%h pend=%h want we=%b regw=%h dataw=%h pend=%h",
                 c, write_en, regw, dataw, pending, m_we, m_regw, m_dataw, m_pend);
      end
    end
    rst       = 1'b0;
    req_valid = '0;
    rsv_valid = 1'b0;
    tick();
  endtask

  initial begin
    m_lg       = N - 1;
    m_we       = 1'b0;
    m_regw     = '0;
    m_dataw    = '0;
    m_pend     = '0;
    m_last_acc = -1;
    test_reset();
    test_round_robin();
    test_single();
    test_reserve();
    test_set_wins();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 4, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, register data width.
REQ-003 SHALL have parameter NUM_REQ, default 3, number of write requesters (legal range 2..8).
REQ-004 SHALL use one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst  input  1  synchronous active-high reset.
REQ-006 SHALL have req_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have req_addr  input  NUM_REQ*REG_ADDR_WIDTH  packed destination addresses, requester i at bits [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
REQ-008 SHALL have req_data  input  NUM_REQ*DATA_WIDTH  packed write data, same packing rule.
REQ-009 SHALL have req_ready  output  NUM_REQ  one-hot-or-zero grant/accept.
REQ-010 SHALL have rsv_valid  input  1  reserve destination register (issue-time).
REQ-011 SHALL have rsv_addr  input  REG_ADDR_WIDTH  register to reserve.
REQ-012 SHALL have write_en  output  1  register file write enable.
REQ-013 SHALL have regw  output  REG_ADDR_WIDTH  register file write address.
REQ-014 SHALL have dataw  output  DATA_WIDTH  register file write data.
REQ-015 SHALL have pending  output  2**REG_ADDR_WIDTH  scoreboard, bit r = write to r outstanding.

Function
REQ-016 SHALL accept request i in a cycle where req_valid[i] and req_ready[i] are both 1 (transfer).
REQ-017 SHALL compute req_ready combinationally from req_valid and the round-robin pointer; at most one bit set; req_ready[i] never set without req_valid[i].
REQ-018 SHALL grant every cycle any requester is valid (no idle bubbles; throughput one write per cycle).
REQ-019 SHALL grant the first valid requester searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
REQ-020 SHALL update last_grant to the granted index on a transfer and hold it otherwise.
REQ-021 SHALL register the transfer: write_en=1, regw=req_addr[i], dataw=req_data[i] in the cycle after the transfer (latency 1).
REQ-022 SHALL drive write_en=0 in a cycle following one with no transfer; regw/dataw hold last values.
REQ-023 SHALL require requesters to hold req_valid, req_addr, req_data stable until accepted; behaviour otherwise undefined.
REQ-024 SHALL set pending[rsv_addr] at the clock edge where rsv_valid=1.
REQ-025 SHALL clear pending[regw] at the clock edge where write_en=1.
REQ-026 SHALL let set win when reservation and clear target the same register in the same cycle (pending stays 1).
REQ-027 SHALL keep pending at 1 when reserving an already-pending register (single bit, no count); one write clears it.
REQ-028 SHALL allow writes to unreserved registers; clearing an already-0 bit leaves it 0.
REQ-029 SHALL accept all register addresses 0..2**REG_ADDR_WIDTH-1 uniformly (no hardwired register).

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set write_en=0, regw=0, dataw=0, pending=0, last_grant=NUM_REQ-1 (requester 0 highest priority next).
REQ-031 SHALL drive req_ready=0 while rst=1; no transfer occurs and no reservation is recorded during reset.
REQ-032 SHALL discard a transfer accepted in the cycle before rst asserts: write_en is 0 on the first cycle after the reset edge.

Verification
REQ-033 Reset then req_valid=3'b111 held -> req_ready sequence 001,010,100,001; write_en=1 from cycle after first grant, regw/dataw match each granted requester.
REQ-034 Only req 2 valid, addr=5, data=8'hA5 -> req_ready=100 same cycle; next cycle write_en=1, regw=5, dataw=8'hA5; following cycle write_en=0.
REQ-035 rsv_valid=1 rsv_addr=3, later req 0 writes addr 3 -> pending[3]=1 after reserve edge, 0 after write_en edge; other bits 0.
REQ-036 write_en=1 regw=7 while rsv_valid=1 rsv_addr=7 same cycle -> pending[7]=1 after edge.
REQ-037 After grant to req 1, req_valid=3'b011 -> next grant req 0 (wrap), then req 1.
REQ-038 rst asserted while req_valid=3'b111 and pending nonzero -> req_ready=0, pending=0, write_en=0; after release first grant is req 0.
